// File: rtl/sdram_device_model.sv
`default_nettype none
// ============================================================================
// Module      : sdram_device_model
// Description : Cycle-level 16-bit SDR SDRAM responder (MT48LC16M16 subset).
//               It decodes commands, tracks open rows, serves reads and writes,
//               and flags illegal commands.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_device_model #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 9,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_ba,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic [1:0]  sd_dq_oe,
  output logic        mode_ok,
  output logic [1:0]  cas_lat,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_cnt
);
  localparam logic [2:0] C_CMD_ACT = 3'b011;
  localparam logic [2:0] C_CMD_RD  = 3'b101;
  localparam logic [2:0] C_CMD_WR  = 3'b100;
  localparam logic [2:0] C_CMD_BT  = 3'b110;
  localparam logic [2:0] C_CMD_PRE = 3'b010;
  localparam logic [2:0] C_CMD_REF = 3'b001;
  localparam logic [2:0] C_CMD_LMR = 3'b000;
  localparam int         C_AW      = 2 + ROW_BITS + COL_BITS;
  localparam int         C_DEPTH   = 1 << C_AW;
  localparam logic [2:0] C_TRCD    = 3'(T_RCD);
  localparam logic [2:0] C_TRP     = 3'(T_RP);

  typedef enum logic {BANK_IDLE = 1'b0, BANK_ACTIVE = 1'b1} bank_st_t;

  bank_st_t            r_bank_st [4];
  bank_st_t            w_bank_st_nxt [4];
  logic [2:0]          r_timer [4];
  logic [2:0]          w_timer_nxt [4];
  logic [ROW_BITS-1:0] r_row [4];
  logic [15:0]         r_mem [C_DEPTH];

  logic [2:0]      w_cmd;
  logic [C_AW-1:0] w_idx;
  logic            w_any_active, w_rw_ok, w_drop;
  logic            w_err, w_wr_en, w_rd_en, w_lmr_ok, w_ref_inc, w_row_ld;
  logic [2:0]      w_code;
  logic            w_unused;

  logic        r_pa_vld, r_pa_long, r_pb_vld;
  logic [15:0] r_pa_data, r_pb_data;
  logic [1:0]  r_pa_oe, r_pb_oe;

  assign w_cmd    = sd_cs ? 3'b111 : {sd_ras, sd_cas, sd_we};
  assign w_idx    = {sd_ba, r_row[sd_ba], sd_addr[COL_BITS-1:0]};
  assign w_rw_ok  = (r_bank_st[sd_ba] == BANK_ACTIVE) && (r_timer[sd_ba] >= C_TRCD);
  assign w_drop   = (w_cmd == C_CMD_WR);
  assign w_unused = ^sd_addr[12:11];

  always_comb begin
    w_any_active = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (r_bank_st[b] == BANK_ACTIVE) w_any_active = 1'b1;
    end
  end

  always_comb begin
    w_err     = 1'b0;
    w_code    = 3'd0;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_lmr_ok  = 1'b0;
    w_ref_inc = 1'b0;
    w_row_ld  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      w_bank_st_nxt[b] = r_bank_st[b];
      w_timer_nxt[b]   = (r_timer[b] == 3'd7) ? 3'd7 : r_timer[b] + 3'd1;
    end
    case (w_cmd)
      C_CMD_ACT: begin
        if (!mode_ok) begin
          w_err = 1'b1; w_code = 3'd1;
        end else if (r_bank_st[sd_ba] == BANK_ACTIVE || r_timer[sd_ba] < C_TRP) begin
          w_err = 1'b1; w_code = 3'd3;
        end else begin
          w_bank_st_nxt[sd_ba] = BANK_ACTIVE;
          w_timer_nxt[sd_ba]   = 3'd1;
          w_row_ld             = 1'b1;
        end
      end
      C_CMD_RD, C_CMD_WR: begin
        if (!mode_ok) begin
          w_err = 1'b1; w_code = 3'd1;
        end else if (!w_rw_ok) begin
          w_err = 1'b1; w_code = 3'd2;
        end else begin
          w_rd_en = (w_cmd == C_CMD_RD);
          w_wr_en = (w_cmd == C_CMD_WR);
          // Auto-precharge closes the bank right after the access.
          if (sd_addr[10]) begin
            w_bank_st_nxt[sd_ba] = BANK_IDLE;
            w_timer_nxt[sd_ba]   = 3'd1;
          end
        end
      end
      C_CMD_BT: begin
        if (!mode_ok) begin
          w_err = 1'b1; w_code = 3'd1;
        end
      end
      C_CMD_PRE: begin
        for (int b = 0; b < 4; b++) begin
          if (sd_addr[10] || sd_ba == 2'(b)) begin
            w_bank_st_nxt[b] = BANK_IDLE;
            w_timer_nxt[b]   = 3'd1;
          end
        end
      end
      C_CMD_REF: begin
        if (w_any_active) begin
          w_err = 1'b1; w_code = 3'd4;
        end else begin
          w_ref_inc = 1'b1;
        end
      end
      C_CMD_LMR: begin
        if (w_any_active) begin
          w_err = 1'b1; w_code = 3'd4;
        end else if ((sd_addr[6:4] != 3'd2 && sd_addr[6:4] != 3'd3) || sd_addr[2:0] != 3'd0) begin
          w_err = 1'b1; w_code = 3'd5;
        end else begin
          w_lmr_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (!sd_dqm[0]) r_mem[w_idx][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqm[1]) r_mem[w_idx][15:8] <= sd_dq_in[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 4; b++) begin
        r_bank_st[b] <= BANK_IDLE;
        r_timer[b]   <= 3'd7;
        r_row[b]     <= '0;
      end
      mode_ok     <= 1'b0;
      cas_lat     <= 2'd2;
      err         <= 1'b0;
      err_code    <= 3'd0;
      refresh_cnt <= 16'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        r_bank_st[b] <= w_bank_st_nxt[b];
        r_timer[b]   <= w_timer_nxt[b];
      end
      if (w_row_ld) r_row[sd_ba] <= sd_addr[ROW_BITS-1:0];
      if (w_lmr_ok) begin
        mode_ok <= 1'b1;
        cas_lat <= sd_addr[5:4];
      end
      err <= w_err;
      if (w_err) err_code <= w_code;
      if (w_ref_inc) refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // Stage A holds a read for one cycle (CL2 exits here); CL3 reads pass through stage B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pa_vld  <= 1'b0;
      r_pa_long <= 1'b0;
      r_pa_data <= 16'd0;
      r_pa_oe   <= 2'b00;
      r_pb_vld  <= 1'b0;
      r_pb_data <= 16'd0;
      r_pb_oe   <= 2'b00;
      sd_dq_out <= 16'd0;
      sd_dq_oe  <= 2'b00;
    end else begin
      r_pa_vld  <= w_rd_en;
      r_pa_long <= (cas_lat == 2'd3);
      r_pa_data <= r_mem[w_idx];
      r_pa_oe   <= ~sd_dqm;
      r_pb_vld  <= r_pa_vld && r_pa_long && !w_drop;
      r_pb_data <= r_pa_data;
      r_pb_oe   <= r_pa_oe;
      if (!w_drop && r_pa_vld && !r_pa_long) begin
        sd_dq_out <= r_pa_data;
        sd_dq_oe  <= r_pa_oe;
      end else if (!w_drop && r_pb_vld) begin
        sd_dq_out <= r_pb_data;
        sd_dq_oe  <= r_pb_oe;
      end else begin
        sd_dq_out <= 16'd0;
        sd_dq_oe  <= 2'b00;
      end
    end
  end
endmodule
`default_nettype wire
